// File: rtl/wfg_drive_spi_pkg.sv
// Shared definitions for the wfg_drive_spi register block and its configuration sequencer.
package wfg_drive_spi_pkg;

  localparam int unsigned ADR_CTRL   = 32'h0;
  localparam int unsigned ADR_CFG    = 32'h4;
  localparam int unsigned ADR_CLKCFG = 32'h8;
  localparam int unsigned ADR_TEST   = 32'hC;

  // Writable CFG bits; bits 7:6 always read back as 0.
  localparam logic [11:0] CFG_RW_MASK = 12'hF3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_GAP,
    S_CHECK,
    S_DONE,
    S_ERR
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_VERIFY  = 2'd2
  } err_code_t;

endpackage

// File: rtl/wfg_drive_spi_cfg_seq.sv
// Wishbone master that programs the drive_spi registers as one atomic sequence:
// CTRL.EN=0, CFG, CLKCFG, TEST, optional CFG readback check, then CTRL.EN=1.
module wfg_drive_spi_cfg_seq
  import wfg_drive_spi_pkg::*;
#(
  parameter int BUSW    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic              verify_i,
  input  logic [11:0]       cfg_word_i,
  input  logic [7:0]        clkcfg_div_i,
  input  logic              test_lpen_i,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [BUSW/8-1:0] wbm_sel_o,
  output logic [BUSW-1:0]   wbm_adr_o,
  output logic [BUSW-1:0]   wbm_dat_o,
  input  logic [BUSW-1:0]   wbm_dat_i,
  input  logic              wbm_ack_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [1:0]        err_code_o
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  seq_state_t      state_q, state_d;
  err_code_t       err_q, err_d;
  logic [2:0]      step_q, step_d, step_nxt;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            verify_q, lpen_q;
  logic [11:0]     cfg_q;
  logic [7:0]      div_q;
  logic [BUSW-1:0] rd_q;
  logic            step_we;
  logic [BUSW-1:0] step_adr, step_dat;
  logic            bus_act;

  // Step table
  always_comb begin
    step_we  = 1'b1;
    step_adr = BUSW'(ADR_CTRL);
    step_dat = '0;
    case (step_q)
      3'd0: step_dat = '0;
      3'd1: begin step_adr = BUSW'(ADR_CFG);    step_dat = BUSW'(cfg_q); end
      3'd2: begin step_adr = BUSW'(ADR_CLKCFG); step_dat = BUSW'(div_q); end
      3'd3: begin step_adr = BUSW'(ADR_TEST);   step_dat = BUSW'({lpen_q, 1'b0}); end
      3'd4: begin step_we  = 1'b0;              step_adr = BUSW'(ADR_CFG); end
      default: step_dat = BUSW'(1'b1);
    endcase
  end

  assign step_nxt = (step_q == 3'd3 && !verify_q) ? 3'd5 : step_q + 3'd1;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_REQ;
        step_d  = 3'd0;
        err_d   = ERR_NONE;
      end
      S_REQ: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wbm_ack_i) state_d = S_GAP;
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERR;
          err_d   = ERR_TIMEOUT;
        end else tmo_d = tmo_q + TW'(1);
      end
      // Acks arriving here are the slave's trailing registered ack and are dropped.
      S_GAP: begin
        if (step_q == 3'd4) state_d = S_CHECK;
        else if (step_q == 3'd5) state_d = S_DONE;
        else begin
          step_d  = step_nxt;
          state_d = S_REQ;
        end
      end
      S_CHECK: begin
        if (rd_q == BUSW'(cfg_q & CFG_RW_MASK)) begin
          step_d  = 3'd5;
          state_d = S_REQ;
        end else begin
          state_d = S_ERR;
          err_d   = ERR_VERIFY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      err_q    <= ERR_NONE;
      step_q   <= '0;
      tmo_q    <= '0;
      verify_q <= 1'b0;
      lpen_q   <= 1'b0;
      cfg_q    <= '0;
      div_q    <= '0;
      rd_q     <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      step_q  <= step_d;
      tmo_q   <= tmo_d;
      if (state_q == S_IDLE && start_i) begin
        verify_q <= verify_i;
        lpen_q   <= test_lpen_i;
        cfg_q    <= cfg_word_i;
        div_q    <= clkcfg_div_i;
      end
      // Readback is masked at capture so unimplemented bits never cause a mismatch.
      if (state_q == S_WAIT && wbm_ack_i && step_q == 3'd4)
        rd_q <= wbm_dat_i & BUSW'(CFG_RW_MASK);
    end
  end

  assign bus_act    = (state_q == S_REQ) || (state_q == S_WAIT);
  assign wbm_cyc_o  = bus_act;
  assign wbm_stb_o  = bus_act;
  assign wbm_we_o   = bus_act && step_we;
  assign wbm_sel_o  = '1;
  assign wbm_adr_o  = bus_act ? step_adr : '0;
  assign wbm_dat_o  = bus_act ? step_dat : '0;
  assign busy_o     = bus_act || (state_q == S_GAP) || (state_q == S_CHECK);
  assign done_o     = (state_q == S_DONE);
  assign error_o    = (state_q == S_ERR);
  assign err_code_o = err_q;

endmodule

// File: tb/tb_wfg_drive_spi_cfg_seq.sv
// Directed bench for wfg_drive_spi_cfg_seq with a behavioural register-slave model.
module tb_wfg_drive_spi_cfg_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, verify = 1'b0, lpen = 1'b0;
  logic [11:0] cfg_word = '0;
  logic [7:0]  div = '0;
  logic        cyc, stb, we, ack, busy, done, error;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;
  logic [1:0]  err_code;

  int n_pass = 0, n_total = 0;

  // slave model controls and state
  int          slv_dly = 1;
  bit          slv_rd0 = 1'b0, slv_noack8 = 1'b0;
  int          s_cnt = 0;
  logic        s_ack = 1'b0;
  logic [31:0] regs [4] = '{default: 32'h0};
  int n_xact = 0, n_wr = 0, n_en1 = 0, n_done = 0, n_cyc = 0;

  always #5 clk = ~clk;

  wfg_drive_spi_cfg_seq #(.BUSW(32), .TIMEOUT(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .verify_i(verify),
    .cfg_word_i(cfg_word), .clkcfg_div_i(div), .test_lpen_i(lpen),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i), .wbm_ack_i(ack),
    .busy_o(busy), .done_o(done), .error_o(error), .err_code_o(err_code)
  );

  // Registered ack: rises slv_dly cycles into a request and stays high one cycle
  // past the handshake, like a slave whose ack is a plain flop of cyc&stb.
  always @(posedge clk) begin
    if (rst) begin
      s_cnt <= 0;
      s_ack <= 1'b0;
    end else if (cyc && stb) begin
      s_cnt <= s_cnt + 1;
      s_ack <= (s_cnt + 1 >= slv_dly) && !(slv_noack8 && adr == 32'h8);
    end else begin
      s_cnt <= 0;
      s_ack <= 1'b0;
    end
  end
  assign ack   = s_ack;
  assign dat_i = (slv_rd0 && adr == 32'h4) ? 32'h0 : regs[adr[3:2]];

  always @(posedge clk) begin
    if (cyc && stb && ack) begin
      n_xact <= n_xact + 1;
      if (we) begin
        regs[adr[3:2]] <= dat_o;
        n_wr <= n_wr + 1;
        if (adr == 32'h0 && dat_o == 32'h1) n_en1 <= n_en1 + 1;
      end
    end
    if (done) n_done <= n_done + 1;
    if (cyc) n_cyc <= n_cyc + 1;
  end

  task automatic run_seq(input logic [11:0] c, input logic [7:0] d, input logic lp,
                         input logic vf, output int lat, output logic busy1);
    @(posedge clk); #1;
    cfg_word = c; div = d; lpen = lp; verify = vf; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy1 = busy;
    lat = 0;
    while (!(done || error) && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if ({cyc, stb, we} !== 3'b000) $display("FAIL reset_bus: got %b expected 000", {cyc, stb, we}); else n_pass++;
    n_total++; if ({busy, done, error} !== 3'b000) $display("FAIL reset_status: got %b expected 000", {busy, done, error}); else n_pass++;
    n_total++; if (err_code !== 2'd0) $display("FAIL reset_err_code: got %0d expected 0", err_code); else n_pass++;
    n_total++; if (adr !== 32'h0 || dat_o !== 32'h0) $display("FAIL reset_adr_dat: got %h/%h expected 0/0", adr, dat_o); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_no_verify;
    int lat, x0, w0; logic b1;
    slv_dly = 1; slv_rd0 = 0; slv_noack8 = 0;
    x0 = n_xact; w0 = n_wr;
    run_seq(12'h5A7, 8'h13, 1'b1, 1'b0, lat, b1);
    n_total++; if (b1 !== 1'b1) $display("FAIL nv_busy: got %b expected 1", b1); else n_pass++;
    n_total++; if (lat !== 15 || done !== 1'b1) $display("FAIL nv_done_latency: got %0d done=%b expected 15 done=1", lat, done); else n_pass++;
    n_total++; if (n_xact - x0 !== 5 || n_wr - w0 !== 5) $display("FAIL nv_xact_count: got %0d/%0d expected 5/5", n_xact - x0, n_wr - w0); else n_pass++;
    n_total++; if (regs[1] !== 32'h5A7 || regs[2] !== 32'h13 || regs[3] !== 32'h2)
      $display("FAIL nv_regs: got %h %h %h expected 5a7 13 2", regs[1], regs[2], regs[3]); else n_pass++;
    n_total++; if (regs[0] !== 32'h1) $display("FAIL nv_ctrl_en: got %h expected 1", regs[0]); else n_pass++;
    n_total++; if (busy !== 1'b0 || err_code !== 2'd0) $display("FAIL nv_status: got busy=%b err=%0d expected 0/0", busy, err_code); else n_pass++;
  endtask

  task automatic test_verify;
    int lat, x0, w0; logic b1;
    x0 = n_xact; w0 = n_wr;
    run_seq(12'h5A7, 8'h13, 1'b1, 1'b1, lat, b1);
    n_total++; if (lat !== 19 || done !== 1'b1) $display("FAIL v_done_latency: got %0d done=%b expected 19 done=1", lat, done); else n_pass++;
    n_total++; if (n_xact - x0 !== 6 || n_wr - w0 !== 5) $display("FAIL v_xact_count: got %0d/%0d expected 6/5", n_xact - x0, n_wr - w0); else n_pass++;
    n_total++; if (err_code !== 2'd0 || regs[0] !== 32'h1) $display("FAIL v_status: got err=%0d ctrl=%h expected 0/1", err_code, regs[0]); else n_pass++;
  endtask

  task automatic test_verify_mismatch;
    int lat, x0, e0; logic b1;
    slv_rd0 = 1;
    x0 = n_xact; e0 = n_en1;
    run_seq(12'h001, 8'h13, 1'b0, 1'b1, lat, b1);
    n_total++; if (lat !== 16 || error !== 1'b1 || done !== 1'b0) $display("FAIL vm_error: got lat=%0d err=%b done=%b expected 16/1/0", lat, error, done); else n_pass++;
    n_total++; if (err_code !== 2'd2) $display("FAIL vm_err_code: got %0d expected 2", err_code); else n_pass++;
    n_total++; if (n_en1 - e0 !== 0 || regs[0] !== 32'h0) $display("FAIL vm_ctrl_en: got writes=%0d ctrl=%h expected 0/0", n_en1 - e0, regs[0]); else n_pass++;
    n_total++; if (n_xact - x0 !== 5) $display("FAIL vm_xact_count: got %0d expected 5", n_xact - x0); else n_pass++;
    slv_rd0 = 0;
  endtask

  task automatic test_timeout;
    int lat, c0; logic b1;
    slv_noack8 = 1;
    c0 = n_cyc;
    run_seq(12'hC21, 8'h77, 1'b1, 1'b0, lat, b1);
    n_total++; if (lat !== 23 || error !== 1'b1) $display("FAIL to_error: got lat=%0d err=%b expected 23/1", lat, error); else n_pass++;
    n_total++; if (n_cyc - c0 !== 21) $display("FAIL to_cyc_cycles: got %0d expected 21", n_cyc - c0); else n_pass++;
    n_total++; if (cyc !== 1'b0 || busy !== 1'b0 || err_code !== 2'd1) $display("FAIL to_status: got cyc=%b busy=%b err=%0d expected 0/0/1", cyc, busy, err_code); else n_pass++;
    n_total++; if (regs[2] !== 32'h13 || regs[1] !== 32'hC21) $display("FAIL to_regs: got %h %h expected 13 c21", regs[2], regs[1]); else n_pass++;
    repeat (5) @(posedge clk);
    #1;
    n_total++; if (err_code !== 2'd1) $display("FAIL to_err_hold: got %0d expected 1", err_code); else n_pass++;
    slv_noack8 = 0;
  endtask

  task automatic test_back_to_back;
    int lat, x0, d0;
    slv_dly = 3;
    x0 = n_xact; d0 = n_done;
    @(posedge clk); #1;
    cfg_word = 12'h3C5; div = 8'h44; lpen = 1'b0; verify = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!(done || error) && lat < 400) begin
      @(posedge clk); #1;
      lat++;
      start = (lat == 5);
      if (lat == 5) begin cfg_word = 12'h0FF; div = 8'h99; verify = 1'b1; end
    end
    start = 1'b0;
    n_total++; if (lat !== 25 || done !== 1'b1) $display("FAIL b2b_latency: got %0d done=%b expected 25 done=1", lat, done); else n_pass++;
    n_total++; if (regs[1] !== 32'h3C5 || regs[2] !== 32'h44 || regs[3] !== 32'h0)
      $display("FAIL b2b_regs: got %h %h %h expected 3c5 44 0", regs[1], regs[2], regs[3]); else n_pass++;
    n_total++; if (n_xact - x0 !== 5) $display("FAIL b2b_xact_count: got %0d expected 5", n_xact - x0); else n_pass++;
    repeat (30) @(posedge clk);
    #1;
    n_total++; if (n_done - d0 !== 1 || busy !== 1'b0) $display("FAIL b2b_single_done: got %0d busy=%b expected 1/0", n_done - d0, busy); else n_pass++;
    slv_dly = 1;
  endtask

  task automatic test_reset_mid;
    int lat; logic b1;
    @(posedge clk); #1;
    cfg_word = 12'h111; div = 8'h22; lpen = 1'b0; verify = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    n_total++; if (cyc !== 1'b1 || adr !== 32'h8) $display("FAIL rm_in_step2: got cyc=%b adr=%h expected 1/8", cyc, adr); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    n_total++; if ({cyc, stb, busy} !== 3'b000 || err_code !== 2'd0)
      $display("FAIL rm_dropped: got %b err=%0d expected 000/0", {cyc, stb, busy}, err_code); else n_pass++;
    rst = 1'b0;
    run_seq(12'h5A7, 8'h13, 1'b1, 1'b0, lat, b1);
    n_total++; if (lat !== 15 || done !== 1'b1 || regs[0] !== 32'h1) $display("FAIL rm_restart: got lat=%0d done=%b ctrl=%h expected 15/1/1", lat, done, regs[0]); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_no_verify;
    test_verify;
    test_verify_mismatch;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
